veda_arbiter: RTL

Two-port round-robin arbiter and sequencer for the 32×32 `veda` register memory. Two requesters issue single-word read or write transactions through a req/ack handshake. The block serialises them onto the memory's single `write_en`/`mode`/`addr`/`data_in` port and returns `data_out` to the winner. After every reset it zero-fills the memory, because the memory's own reset leaves contents undefined.

---
 rtl/veda_arbiter_pkg.sv | 24 ++
 rtl/veda_arbiter_if.sv | 53 +++++
 rtl/veda_arbiter_rr_pick.sv | 23 ++
 rtl/veda_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/veda_arbiter_pkg.sv
// Shared types and constants for the veda register-memory arbiter.
package veda_pkg;

    localparam int VEDA_DATA_W = 32;
    localparam int VEDA_ADDR_W = 5;

    // Port-select encoding, also used for last_grant.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } veda_state_e;

    // The port that did not win most recently.
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/veda_arbiter_if.sv
// Requester handshake and memory command bus of the veda arbiter.
interface veda_arbiter_if
    import veda_pkg::*;
#(
    parameter int DATA_W = VEDA_DATA_W,
    parameter int ADDR_W = VEDA_ADDR_W
);

    // Requester A
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              ack_a;
    logic [DATA_W-1:0] rdata_a;

    // Requester B
    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              ack_b;
    logic [DATA_W-1:0] rdata_b;

    // Status
    logic              ready;

    // Memory command port
    logic              mem_write_en;
    logic              mem_mode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    // Environment side: requesters plus the memory itself.
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output mem_data_out,
        input  ack_a, rdata_a, ack_b, rdata_b, ready,
        input  mem_write_en, mem_mode, mem_addr, mem_data_in
    );

    // Arbiter side.
    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  mem_data_out,
        output ack_a, rdata_a, ack_b, rdata_b, ready,
        output mem_write_en, mem_mode, mem_addr, mem_data_in
    );

endinterface

// File: rtl/veda_arbiter_rr_pick.sv
// Combinational two-way round-robin selector.
module veda_rr_pick
    import veda_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_sel
);

    // Single requester wins outright; on contention the port not served last wins.
    always_comb begin
        grant_valid = req_a | req_b;
        grant_sel   = PORT_A;
        if (req_a && req_b) begin
            grant_sel = other_port(last_grant);
        end else if (req_b) begin
            grant_sel = PORT_B;
        end
    end

endmodule

// File: rtl/veda_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 32x32 veda register memory.
// Zero-fills the memory after reset, then serialises single-word transactions.
module veda_arbiter
    import veda_pkg::*;
#(
    parameter int DATA_W    = VEDA_DATA_W,
    parameter int ADDR_W    = VEDA_ADDR_W,
    parameter int INIT_ZERO = 1
)
(
    input  logic          clk,
    input  logic          rst,
    veda_arbiter_if.slave bus
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    veda_state_e       state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              last_grant, last_grant_nxt;
    logic              gsel, gsel_nxt;

    logic              grant_valid;
    logic              grant_sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              ready_q, ready_nxt;
    logic              we_q, we_nxt;
    logic              mode_q, mode_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_in_q, data_in_nxt;
    logic              ack_a_q, ack_a_nxt;
    logic              ack_b_q, ack_b_nxt;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_nxt;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_nxt;

    veda_rr_pick u_pick (
        .req_a       (bus.req_a),
        .req_b       (bus.req_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // Route the winning requester's command fields.
    always_comb begin
        if (grant_sel == PORT_B) begin
            sel_we    = bus.we_b;
            sel_addr  = bus.addr_b;
            sel_wdata = bus.wdata_b;
        end else begin
            sel_we    = bus.we_a;
            sel_addr  = bus.addr_a;
            sel_wdata = bus.wdata_a;
        end
    end

    // State register plus all datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= (INIT_ZERO != 0) ? INIT : IDLE;
            cnt        <= '0;
            last_grant <= PORT_B;
            gsel       <= PORT_A;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            mode_q     <= 1'b0;
            addr_q     <= '0;
            data_in_q  <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            gsel       <= gsel_nxt;
            ready_q    <= ready_nxt;
            we_q       <= we_nxt;
            mode_q     <= mode_nxt;
            addr_q     <= addr_nxt;
            data_in_q  <= data_in_nxt;
            ack_a_q    <= ack_a_nxt;
            ack_b_q    <= ack_b_nxt;
            rdata_a_q  <= rdata_a_nxt;
            rdata_b_q  <= rdata_b_nxt;
        end
    end

    // Next-state: init sweep, then a fixed four-cycle transaction loop.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (cnt == LAST_ADDR) state_nxt = IDLE;
            IDLE:    if (grant_valid)      state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping for the current state.
    always_comb begin
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        gsel_nxt       = gsel;
        ready_nxt      = ready_q;
        we_nxt         = we_q;
        mode_nxt       = mode_q;
        addr_nxt       = addr_q;
        data_in_nxt    = data_in_q;
        ack_a_nxt      = 1'b0;
        ack_b_nxt      = 1'b0;
        rdata_a_nxt    = rdata_a_q;
        rdata_b_nxt    = rdata_b_q;

        case (state)
            INIT: begin
                we_nxt      = 1'b1;
                mode_nxt    = 1'b0;
                addr_nxt    = cnt;
                data_in_nxt = '0;
                cnt_nxt     = cnt + ADDR_W'(1);
            end
            IDLE: begin
                ready_nxt = 1'b1;
                we_nxt    = 1'b0;
                if (grant_valid) begin
                    we_nxt         = 1'b1;
                    mode_nxt       = ~sel_we;
                    addr_nxt       = sel_addr;
                    data_in_nxt    = sel_we ? sel_wdata : '0;
                    last_grant_nxt = grant_sel;
                    gsel_nxt       = grant_sel;
                end
            end
            ISSUE: begin
                we_nxt = 1'b0;
            end
            WAIT: begin
                // Memory registered its output on the ISSUE edge; hand it to the winner.
                if (gsel == PORT_B) begin
                    rdata_b_nxt = bus.mem_data_out;
                    ack_b_nxt   = 1'b1;
                end else begin
                    rdata_a_nxt = bus.mem_data_out;
                    ack_a_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ready        = ready_q;
    assign bus.mem_write_en = we_q;
    assign bus.mem_mode     = mode_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_in  = data_in_q;
    assign bus.ack_a        = ack_a_q;
    assign bus.ack_b        = ack_b_q;
    assign bus.rdata_a      = rdata_a_q;
    assign bus.rdata_b      = rdata_b_q;

endmodule
